// File: rtl/stage2_pkg.sv
// Shared types, widths, Q-format constants and output saturation for the
// AILayerNorm Stage2 normaliser.
package stage2_pkg;

  localparam int X_W   = 9;
  localparam int EX_W  = 22;
  localparam int EX2_W = 32;
  localparam int Y_W   = 16;

  localparam int EX_FRAC  = 8;
  localparam int EX2_FRAC = 16;
  localparam int Y_FRAC   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VAR,
    S_SQRT,
    S_DIV,
    S_OUT
  } state_e;

  function automatic logic signed [Y_W-1:0] sat16(input logic signed [47:0] v);
    if (v > 48'sd32767) begin
      return 16'sh7FFF;
    end
    if (v < -48'sd32768) begin
      return 16'sh8000;
    end
    return v[Y_W-1:0];
  endfunction

endpackage

// File: rtl/isqrt_u32.sv
// Restoring bit-serial integer square root: floor(sqrt(i_rad)) in 16 cycles.
// o_done and o_root are valid together in the cycle of the final iteration.
module isqrt_u32 (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [31:0] i_rad,
  output logic        o_done,
  output logic [15:0] o_root
);

  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rad_q, rad_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [19:0] rem_sh, trial;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    o_done = 1'b0;
    rem_sh = {rem_q, rad_q[31:30]};
    trial  = {2'b00, root_q, 2'b01};
    if (i_start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rad_d  = i_rad;
      rem_d  = '0;
      root_d = '0;
    end else if (busy_q) begin
      rad_d = {rad_q[29:0], 2'b00};
      cnt_d = cnt_q + 4'd1;
      // remainder never exceeds 2*root, so 18 bits always hold it
      if (rem_sh >= trial) begin
        rem_d  = 18'(rem_sh - trial);
        root_d = {root_q[14:0], 1'b1};
      end else begin
        rem_d  = rem_sh[17:0];
        root_d = {root_q[14:0], 1'b0};
      end
      if (cnt_q == 4'd15) begin
        o_done = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  assign o_root = root_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    rad_q  <= rad_d;
    rem_q  <= rem_d;
    root_q <= root_d;
  end

endmodule

// File: rtl/stage2_norm.sv
// AILayerNorm Stage2: buffers x_norm, derives std and 1/std, streams y.
// Define STAGE2_AFFINE_EN to add gamma/beta scaling on the output.
module stage2_norm
  import stage2_pkg::*;
#(
  parameter int N   = 8,
  parameter int EPS = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_valid,
  input  logic signed [X_W-1:0]  i_x_norm,
  input  logic                   i_S1_done,
  input  logic signed [EX_W-1:0] i_Ex,
  input  logic [EX2_W-1:0]       i_Ex2,
`ifdef STAGE2_AFFINE_EN
  input  logic signed [7:0]      i_gamma,
  input  logic signed [Y_W-1:0]  i_beta,
`endif
  output logic                   o_valid,
  output logic signed [Y_W-1:0]  o_y,
  output logic [Y_W-1:0]         o_inv_std,
  output logic                   o_busy,
  output logic                   o_S2_done
);

  localparam int PTR_W    = $clog2(N + 1);
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam int SQ_SHIFT = 2 * EX_FRAC - EX2_FRAC;
  localparam int G_FRAC   = 6;
  localparam logic signed [44:0] VAR_MAX = 45'sh0_FFFF_FFFF - 45'(EPS);
  localparam logic [PTR_W-1:0]   N_PTR   = PTR_W'(N);
  localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rd_idx_q, rd_idx_d;
  logic [3:0]             div_cnt_q, div_cnt_d;
  logic                   o_valid_q, o_valid_d;
  logic                   o_done_q, o_done_d;
  logic signed [Y_W-1:0]  o_y_q, o_y_d;
  logic [Y_W-1:0]         o_inv_q, o_inv_d;

  logic signed [X_W-1:0]  buf_q [N];
  logic                   buf_we;
  logic signed [EX_W-1:0] ex_q, ex_d;
  logic [EX2_W-1:0]       ex2_q, ex2_d;
  logic [15:0]            std_q, std_d;
  logic [15:0]            rem_q, rem_d;
  logic [15:0]            quo_q, quo_d;
`ifdef STAGE2_AFFINE_EN
  logic signed [7:0]      gamma_q, gamma_d;
  logic signed [Y_W-1:0]  beta_q, beta_d;
  logic signed [23:0]     yg;
  logic signed [47:0]     yg_w, yg_sh, beta_w, aff_sum;
`endif

  logic                   sqrt_start, sqrt_done;
  logic [15:0]            sqrt_root;
  logic signed [43:0]     ex_w, sq, sq_al;
  logic signed [44:0]     var_diff, var_sat;
  logic [31:0]            var_c;
  logic [16:0]            rem_sh, rem_sub;
  logic                   div_ge, emit;
  logic [15:0]            quo_step, inv_next, inv_use;
  logic signed [X_W-1:0]  rd_x;
  logic signed [23:0]     diff;
  logic signed [40:0]     prod;
  logic signed [47:0]     prod_w, y_w;
  logic signed [Y_W-1:0]  y_norm, y_out;
  logic                   unused_bits;

  assign unused_bits = ^{sq_al[43:32], var_sat[44:32], rem_sub[16], quo_q[15]};

  isqrt_u32 u_isqrt (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_start (sqrt_start),
    .i_rad   (var_c),
    .o_done  (sqrt_done),
    .o_root  (sqrt_root)
  );

  // Datapath: variance, one divider step, and the output sample
  always_comb begin
    ex_w     = {{(44 - EX_W){ex_q[EX_W-1]}}, ex_q};
    sq       = ex_w * ex_w;
    sq_al    = sq >>> SQ_SHIFT;
    var_diff = $signed({13'd0, ex2_q}) - $signed({13'd0, sq_al[31:0]});
    if (var_diff < 0) begin
      var_sat = '0;
    end else if (var_diff > VAR_MAX) begin
      var_sat = VAR_MAX;
    end else begin
      var_sat = var_diff;
    end
    var_c = var_sat[31:0] + 32'(EPS);

    // 2^16 / std: the dividend's bit 16 is preloaded as remainder 1
    rem_sh   = {rem_q, 1'b0};
    rem_sub  = rem_sh - {1'b0, std_q};
    div_ge   = (rem_sh >= {1'b0, std_q});
    quo_step = {quo_q[14:0], div_ge};
    inv_next = (std_q <= 16'd1) ? 16'hFFFF : quo_step;
    inv_use  = (state_q == S_DIV) ? inv_next : o_inv_q;

    rd_x   = buf_q[rd_idx_q[IDX_W-1:0]];
    diff   = {{(24 - X_W - EX_FRAC){rd_x[X_W-1]}}, rd_x, {EX_FRAC{1'b0}}}
           - {{(24 - EX_W){ex_q[EX_W-1]}}, ex_q};
    prod   = {{17{diff[23]}}, diff} * {25'd0, inv_use};
    prod_w = {{7{prod[40]}}, prod};
    y_w    = prod_w >>> Y_FRAC;
    y_norm = sat16(y_w);
`ifdef STAGE2_AFFINE_EN
    yg      = {{8{y_norm[Y_W-1]}}, y_norm} * {{16{gamma_q[7]}}, gamma_q};
    yg_w    = {{24{yg[23]}}, yg};
    yg_sh   = yg_w >>> G_FRAC;
    beta_w  = {{32{beta_q[Y_W-1]}}, beta_q};
    aff_sum = yg_sh + beta_w;
    y_out   = sat16(aff_sum);
`else
    y_out   = y_norm;
`endif
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rd_idx_d   = rd_idx_q;
    div_cnt_d  = div_cnt_q;
    o_valid_d  = 1'b0;
    o_done_d   = 1'b0;
    o_y_d      = o_y_q;
    o_inv_d    = o_inv_q;
    ex_d       = ex_q;
    ex2_d      = ex2_q;
    std_d      = std_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    buf_we     = 1'b0;
    sqrt_start = 1'b0;
    emit       = 1'b0;
`ifdef STAGE2_AFFINE_EN
    gamma_d    = gamma_q;
    beta_d     = beta_q;
`endif
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (i_valid) begin
          if (state_q == S_IDLE) state_d = S_COLLECT;
          if (wptr_q < N_PTR) begin
            buf_we = 1'b1;
            wptr_d = wptr_q + PTR_ONE;
          end
        end
        if (i_S1_done) begin
          ex_d    = i_Ex;
          ex2_d   = i_Ex2;
`ifdef STAGE2_AFFINE_EN
          gamma_d = i_gamma;
          beta_d  = i_beta;
`endif
          state_d = S_VAR;
        end
      end
      S_VAR: begin
        sqrt_start = 1'b1;
        state_d    = S_SQRT;
      end
      S_SQRT: begin
        if (sqrt_done) begin
          std_d     = sqrt_root;
          rem_d     = 16'd1;
          quo_d     = '0;
          div_cnt_d = '0;
          rd_idx_d  = '0;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        rem_d     = div_ge ? rem_sub[15:0] : rem_sh[15:0];
        quo_d     = quo_step;
        div_cnt_d = div_cnt_q + 4'd1;
        // first sample is formed from the fresh quotient so it lands right at DIV exit
        if (div_cnt_q == 4'd15) begin
          o_inv_d = inv_next;
          if (wptr_q == '0) begin
            o_done_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            emit    = 1'b1;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (rd_idx_q == wptr_q) begin
          wptr_d  = '0;
          state_d = S_IDLE;
        end else begin
          emit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      o_valid_d = 1'b1;
      o_y_d     = y_out;
      rd_idx_d  = rd_idx_q + PTR_ONE;
      o_done_d  = ((rd_idx_q + PTR_ONE) == wptr_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rd_idx_q  <= '0;
      div_cnt_q <= '0;
      o_valid_q <= 1'b0;
      o_done_q  <= 1'b0;
      o_y_q     <= '0;
      o_inv_q   <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rd_idx_q  <= rd_idx_d;
      div_cnt_q <= div_cnt_d;
      o_valid_q <= o_valid_d;
      o_done_q  <= o_done_d;
      o_y_q     <= o_y_d;
      o_inv_q   <= o_inv_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (buf_we) buf_q[wptr_q[IDX_W-1:0]] <= i_x_norm;
    ex_q  <= ex_d;
    ex2_q <= ex2_d;
    std_q <= std_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
`ifdef STAGE2_AFFINE_EN
    gamma_q <= gamma_d;
    beta_q  <= beta_d;
`endif
  end

  assign o_valid   = o_valid_q;
  assign o_y       = o_y_q;
  assign o_inv_std = o_inv_q;
  assign o_S2_done = o_done_q;
  assign o_busy    = !((state_q == S_IDLE) || (state_q == S_COLLECT));

endmodule

// File: tb/tb_stage2_norm.sv
// Directed bench for stage2_norm: nominal, zero/negative variance, overflow,
// coincident valid/done and asynchronous reset mid-SQRT.
module tb_stage2_norm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn, valid, s1_done;
  logic signed [8:0]  x;
  logic signed [21:0] ex;
  logic [31:0]        ex2;
`ifdef STAGE2_AFFINE_EN
  logic signed [7:0]  gamma;
  logic signed [15:0] beta;
`endif
  logic               o_valid, o_busy, o_S2_done;
  logic [15:0]        o_y, o_inv_std;

  int n_pass  = 0;
  int n_total = 0;

  logic signed [8:0] xv [16];
  logic [15:0]       yexp [8];

  stage2_norm dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_valid   (valid),
    .i_x_norm  (x),
    .i_S1_done (s1_done),
    .i_Ex      (ex),
    .i_Ex2     (ex2),
`ifdef STAGE2_AFFINE_EN
    .i_gamma   (gamma),
    .i_beta    (beta),
`endif
    .o_valid   (o_valid),
    .o_y       (o_y),
    .o_inv_std (o_inv_std),
    .o_busy    (o_busy),
    .o_S2_done (o_S2_done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 8; i++) begin
      xv[i] = (i % 2 == 0) ? 9'sd8 : -9'sd8;
`ifdef STAGE2_AFFINE_EN
      yexp[i] = (i % 2 == 0) ? 16'hFD00 : 16'h0500;
`else
      yexp[i] = (i % 2 == 0) ? 16'h0200 : 16'hFE00;
`endif
    end
`ifdef STAGE2_AFFINE_EN
    gamma = 8'sh80;
    beta  = 16'sh0100;
`endif
  endtask

  task automatic unity_affine();
`ifdef STAGE2_AFFINE_EN
    gamma = 8'sh40;
    beta  = 16'sh0000;
`endif
  endtask

  task automatic run_frame(input string name, input int nx, input logic signed [21:0] f_ex,
                           input logic [31:0] f_ex2, input logic [15:0] exp_inv,
                           input int n_out, input bit coincide);
    int lat;
    for (int i = 0; i < nx; i++) begin
      valid = 1'b1;
      x     = xv[i];
      if (coincide && i == nx - 1) begin
        s1_done = 1'b1;
        ex      = f_ex;
        ex2     = f_ex2;
      end
      tick();
    end
    if (!(coincide && nx > 0)) begin
      valid   = 1'b0;
      s1_done = 1'b1;
      ex      = f_ex;
      ex2     = f_ex2;
      tick();
    end
    valid   = 1'b0;
    s1_done = 1'b0;
    check({name, ".busy_var"}, o_busy, 1);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check({name, ".latency"}, lat, 34);
    for (int k = 0; k < n_out; k++) begin
      check($sformatf("%s.y%0d", name, k), o_y, yexp[k]);
      check($sformatf("%s.valid%0d", name, k), o_valid, 1);
      check($sformatf("%s.done%0d", name, k), o_S2_done, (k == n_out - 1));
      if (k == 0) check({name, ".inv_std"}, o_inv_std, exp_inv);
      tick();
    end
    check({name, ".valid_end"}, o_valid, 0);
    check({name, ".done_end"}, o_S2_done, 0);
    check({name, ".busy_end"}, o_busy, 0);
    check({name, ".inv_held"}, o_inv_std, exp_inv);
    tick();
  endtask

  initial begin
    rstn    = 1'b0;
    valid   = 1'b0;
    s1_done = 1'b0;
    x       = '0;
    ex      = '0;
    ex2     = '0;
    unity_affine();
    #12;
    check("rst.valid", o_valid, 0);
    check("rst.y", o_y, 0);
    check("rst.inv_std", o_inv_std, 0);
    check("rst.busy", o_busy, 0);
    check("rst.done", o_S2_done, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    set_nominal();
    run_frame("nominal", 8, 22'sd0, 32'h0010_0000, 16'h0040, 8, 1'b0);

    unity_affine();
    xv[0] = 9'sd2;  xv[1] = 9'sd3;  xv[2] = 9'sd1;
    yexp[0] = 16'h0000; yexp[1] = 16'h7FFF; yexp[2] = 16'h8000;
    run_frame("zero_var", 3, 22'sd512, 32'h0004_0000, 16'hFFFF, 3, 1'b0);

    xv[0] = 9'sd4;  xv[1] = 9'sd5;
    yexp[0] = 16'h0000; yexp[1] = 16'h7FFF;
    run_frame("neg_var", 2, 22'sd1024, 32'h0001_0000, 16'hFFFF, 2, 1'b1);

    for (int i = 0; i < 10; i++) xv[i] = 9'(i + 1);
    for (int k = 0; k < 8; k++) yexp[k] = 16'((k + 1) * 64);
    run_frame("overflow", 10, 22'sd0, 32'h0010_0000, 16'h0040, 8, 1'b0);

    set_nominal();
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      x     = xv[i];
      tick();
    end
    valid   = 1'b0;
    s1_done = 1'b1;
    ex      = 22'sd0;
    ex2     = 32'h0010_0000;
    tick();
    s1_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("sqrt.busy_before_rst", o_busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst.valid", o_valid, 0);
    check("arst.y", o_y, 0);
    check("arst.inv_std", o_inv_std, 0);
    check("arst.busy", o_busy, 0);
    check("arst.done", o_S2_done, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    check("arst.idle_after", o_busy, 0);
    run_frame("post_rst", 8, 22'sd0, 32'h0010_0000, 16'h0040, 8, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
